// File: rtl/frame_arb_pkg.sv
// Shared widths, source tags and grant encoding for the frame source arbiter.
package frame_arb_pkg;
  localparam int unsigned FRAME_W = 128;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RUN_W   = 8;

  localparam logic [1:0] SRC_TRACE  = 2'd0;
  localparam logic [1:0] SRC_STATUS = 2'd1;
  localparam logic [1:0] SRC_FILLER = 2'd2;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_TRACE  = 2'd1,
    GNT_STATUS = 2'd2
  } grant_e;
endpackage

// File: rtl/frame_source_arbiter_if.sv
// Ready/Next frame handshake shared by both producers and the packer side.
interface frame_source_arbiter_if;
  logic [frame_arb_pkg::FRAME_W-1:0] frame;
  logic                              frame_ready;
  logic                              frame_next;

  modport master (output frame, output frame_ready, input frame_next);
  modport slave  (input frame, input frame_ready, output frame_next);
endinterface

// File: rtl/frame_arb_select.sv
// Eligibility and trace-preferred priority with bounded status starvation.
module frame_arb_select
  import frame_arb_pkg::*;
#(
  parameter int unsigned MAX_TRACE_RUN = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   enable,
  input  logic   out_free,
  input  logic   tr_ready,
  input  logic   tr_next,
  input  logic   st_ready,
  input  logic   st_next,
  output grant_e grant_c
);

  logic [RUN_W-1:0] tr_run_q, tr_run_d;
  logic             tr_elig, st_elig, starved;

  always_comb begin
    tr_elig  = tr_ready && !tr_next && enable;
    st_elig  = st_ready && !st_next && enable;
    starved  = tr_run_q >= RUN_W'(MAX_TRACE_RUN);
    grant_c  = GNT_NONE;
    tr_run_d = tr_run_q;

    if (out_free) begin
      if (tr_elig && st_elig) grant_c = starved ? GNT_STATUS : GNT_TRACE;
      else if (tr_elig)       grant_c = GNT_TRACE;
      else if (st_elig)       grant_c = GNT_STATUS;
    end

    // Run length only counts trace wins while status is actually waiting.
    if (enable) begin
      if (!st_ready || grant_c == GNT_STATUS)
        tr_run_d = '0;
      else if (grant_c == GNT_TRACE && tr_run_q != {RUN_W{1'b1}})
        tr_run_d = tr_run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tr_run_q <= '0;
    else     tr_run_q <= tr_run_d;
  end

endmodule

// File: rtl/frame_source_arbiter.sv
// Muxes trace/status frames into a single-entry output register for the packer,
// inserting a filler frame after a configurable idle period.
module frame_source_arbiter
  import frame_arb_pkg::*;
#(
  parameter int unsigned         MAX_TRACE_RUN = 8,
  parameter int unsigned         IDLE_TIMEOUT  = 1024,
  parameter logic [FRAME_W-1:0]  FILLER_FRAME  = 128'h7fffffff_7fffffff_7fffffff_7fffffff
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  frame_source_arbiter_if.slave  tr_if,
  frame_source_arbiter_if.slave  st_if,
  frame_source_arbiter_if.master out_if,
  output logic [1:0]             srcTag,
  output logic [CNT_W-1:0]       trCount,
  output logic [CNT_W-1:0]       stCount,
  output logic [CNT_W-1:0]       fillCount
);

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               frame_ready_q, frame_ready_d;
  logic [1:0]         src_tag_q, src_tag_d;
  logic               tr_next_q, tr_next_d;
  logic               st_next_q, st_next_d;
  logic [CNT_W-1:0]   tr_cnt_q, tr_cnt_d;
  logic [CNT_W-1:0]   st_cnt_q, st_cnt_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               out_free_c, idle_c;
  grant_e             grant_c;

  assign out_free_c = !frame_ready_q || out_if.frame_next;

  frame_arb_select #(.MAX_TRACE_RUN(MAX_TRACE_RUN)) u_select (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .out_free (out_free_c),
    .tr_ready (tr_if.frame_ready),
    .tr_next  (tr_next_q),
    .st_ready (st_if.frame_ready),
    .st_next  (st_next_q),
    .grant_c  (grant_c)
  );

  always_comb begin
    frame_d       = frame_q;
    frame_ready_d = frame_ready_q;
    src_tag_d     = src_tag_q;
    tr_next_d     = 1'b0;
    st_next_d     = 1'b0;
    tr_cnt_d      = tr_cnt_q;
    st_cnt_d      = st_cnt_q;
    fill_cnt_d    = fill_cnt_q;
    idle_cnt_d    = '0;
    idle_c        = out_free_c && (grant_c == GNT_NONE) && enable && (IDLE_TIMEOUT != 0);

    if (out_if.frame_next) frame_ready_d = 1'b0;

    unique case (grant_c)
      GNT_TRACE: begin
        frame_d       = tr_if.frame;
        frame_ready_d = 1'b1;
        src_tag_d     = SRC_TRACE;
        tr_next_d     = 1'b1;
        tr_cnt_d      = tr_cnt_q + CNT_W'(1);
      end
      GNT_STATUS: begin
        frame_d       = st_if.frame;
        frame_ready_d = 1'b1;
        src_tag_d     = SRC_STATUS;
        st_next_d     = 1'b1;
        st_cnt_d      = st_cnt_q + CNT_W'(1);
      end
      default: ;
    endcase

    // Filler fires on the IDLE_TIMEOUT-th consecutive idle cycle.
    if (idle_c) begin
      if (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
        frame_d       = FILLER_FRAME;
        frame_ready_d = 1'b1;
        src_tag_d     = SRC_FILLER;
        fill_cnt_d    = fill_cnt_q + CNT_W'(1);
      end else begin
        idle_cnt_d    = idle_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q       <= '0;
      frame_ready_q <= 1'b0;
      src_tag_q     <= SRC_TRACE;
      tr_next_q     <= 1'b0;
      st_next_q     <= 1'b0;
      tr_cnt_q      <= '0;
      st_cnt_q      <= '0;
      fill_cnt_q    <= '0;
      idle_cnt_q    <= '0;
    end else begin
      frame_q       <= frame_d;
      frame_ready_q <= frame_ready_d;
      src_tag_q     <= src_tag_d;
      tr_next_q     <= tr_next_d;
      st_next_q     <= st_next_d;
      tr_cnt_q      <= tr_cnt_d;
      st_cnt_q      <= st_cnt_d;
      fill_cnt_q    <= fill_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  assign out_if.frame       = frame_q;
  assign out_if.frame_ready = frame_ready_q;
  assign tr_if.frame_next   = tr_next_q;
  assign st_if.frame_next   = st_next_q;
  assign srcTag             = src_tag_q;
  assign trCount            = tr_cnt_q;
  assign stCount            = st_cnt_q;
  assign fillCount          = fill_cnt_q;

endmodule
